// File: rtl/audio_out_stage.sv
// Final audio output stage: fractional-rate decimation, DC-blocking high-pass,
// saturating volume/mute and a valid/ready output register with sticky overrun.
module audio_out_stage #(
  parameter int IW        = 16,
  parameter int CLK_HZ    = 53693136,
  parameter int OUT_HZ    = 48000,
  parameter int DCB_SHIFT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] snd_l_in,
  input  logic signed [IW-1:0] snd_r_in,
  input  logic        [7:0]    gain,
  input  logic                 mute,
  output logic signed [IW-1:0] out_l,
  output logic signed [IW-1:0] out_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int AW = $clog2(CLK_HZ) + 1;   // phase accumulator
  localparam int DW = IW + 1;               // input difference
  localparam int YW = IW + 2;               // DC-blocker output
  localparam int SW = YW + DCB_SHIFT;       // DC-blocker state
  localparam int PW = YW + 9;               // full gain product

  localparam logic signed [PW-1:0] P_MAX = {{(PW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  // ---------------------------------------------------------------- phase
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic          tick;

  // acc < CLK_HZ and OUT_HZ < CLK_HZ, so the sum never exceeds AW bits.
  assign acc_sum = acc + AW'(OUT_HZ);
  assign tick    = (acc_sum >= AW'(CLK_HZ));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)     acc <= '0;
    else if (tick) acc <= acc_sum - AW'(CLK_HZ);
    else           acc <= acc_sum;
  end

  // ---------------------------------------------------------------- datapath
  logic                 cap_valid;
  logic                 y_valid;
  logic                 mute_q;
  logic signed [IW-1:0] x_q      [2];
  logic signed [IW-1:0] x_prev   [2];
  logic signed [SW-1:0] s_q      [2];
  logic signed [YW-1:0] y_q      [2];

  logic signed [SW-1:0] diff_ext [2];
  logic signed [SW-1:0] s_next   [2];
  logic signed [YW-1:0] y_next   [2];
  logic signed [8:0]    gain_s;
  logic signed [PW-1:0] prod     [2];
  logic signed [PW-1:0] prod_sh  [2];
  logic signed [IW-1:0] p        [2];

  assign gain_s = {1'b0, gain};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      diff_ext[ch] = '0;
      s_next[ch]   = '0;
      y_next[ch]   = '0;
      prod[ch]     = '0;
      prod_sh[ch]  = '0;
      p[ch]        = '0;

      diff_ext[ch] = SW'(DW'(x_q[ch]) - DW'(x_prev[ch]));
      s_next[ch]   = s_q[ch] + (diff_ext[ch] <<< DCB_SHIFT) - (s_q[ch] >>> DCB_SHIFT);
      // The state's integer part is exactly YW bits wide, so this slice is already saturated.
      y_next[ch]   = s_next[ch][SW-1:DCB_SHIFT];

      prod[ch]     = PW'(y_q[ch]) * PW'(gain_s);
      prod_sh[ch]  = prod[ch] >>> 6;
      if (mute_q)                  p[ch] = '0;
      else if (prod_sh[ch] > P_MAX) p[ch] = P_MAX[IW-1:0];
      else if (prod_sh[ch] < P_MIN) p[ch] = P_MIN[IW-1:0];
      else                         p[ch] = prod_sh[ch][IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      y_valid   <= 1'b0;
      mute_q    <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        x_q[ch]    <= '0;
        x_prev[ch] <= '0;
        s_q[ch]    <= '0;
        y_q[ch]    <= '0;
      end
    end else begin
      cap_valid <= tick;
      y_valid   <= cap_valid;
      if (tick) begin
        x_q[0] <= snd_l_in;
        x_q[1] <= snd_r_in;
      end
      // Filter state advances once per captured sample, muted or not.
      if (cap_valid) begin
        mute_q <= mute;
        for (int ch = 0; ch < 2; ch++) begin
          s_q[ch]    <= s_next[ch];
          x_prev[ch] <= x_q[ch];
          y_q[ch]    <= y_next[ch];
        end
      end
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk) begin
    if (reset) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (y_valid) begin
      out_l     <= p[0];
      out_r     <= p[1];
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed bench for audio_out_stage: two instances (DCB_SHIFT 4 and 10) at a
// 10:3 clock ratio, driven from one linear stimulus sequence.
module tb_audio_out_stage;

  localparam int IW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [IW-1:0] snd_l_in, snd_r_in;
  logic        [7:0]    gain;
  logic                 mute;
  logic                 out_ready;

  logic signed [IW-1:0] a_l, a_r, b_l, b_r;
  logic                 a_valid, b_valid, a_ovr, b_ovr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  audio_out_stage #(.IW(IW), .CLK_HZ(10), .OUT_HZ(3), .DCB_SHIFT(4)) dut_a (
    .clk(clk), .reset(reset), .snd_l_in(snd_l_in), .snd_r_in(snd_r_in),
    .gain(gain), .mute(mute), .out_l(a_l), .out_r(a_r),
    .out_valid(a_valid), .out_ready(out_ready), .overrun(a_ovr)
  );

  audio_out_stage #(.IW(IW), .CLK_HZ(10), .OUT_HZ(3), .DCB_SHIFT(10)) dut_b (
    .clk(clk), .reset(reset), .snd_l_in(snd_l_in), .snd_r_in(snd_r_in),
    .gain(gain), .mute(mute), .out_l(b_l), .out_r(b_r),
    .out_valid(b_valid), .out_ready(out_ready), .overrun(b_ovr)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // Returns at the negedge of cycle 0: the last posedge saw reset, acc = 0.
  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Advances to the next negedge at which dut_a presents a valid sample.
  task automatic get_sample(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (a_valid === 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit exp_v;
    int n_bad;
    int prev_l, prev_r;

    reset = 1'b1; snd_l_in = '0; snd_r_in = '0;
    gain = 8'd64; mute = 1'b0; out_ready = 1'b1;

    // ---- reset state and cadence: ticks in cycles 3,6,9 (mod 10), valid 3 later
    reset_dut();
    check("rst_valid", 32'(a_valid), 0);
    check("rst_l",     32'(a_l), 0);
    check("rst_r",     32'(a_r), 0);
    check("rst_ovr",   32'(a_ovr), 0);
    check("rst_b_val", 32'(b_valid), 0);
    for (int k = 0; k < 30; k++) begin
      exp_v = (k >= 6) && ((k % 10 == 6) || (k % 10 == 9) || (k % 10 == 2));
      check($sformatf("cad_k%0d", k), 32'(a_valid), 32'(exp_v));
      @(negedge clk);
    end

    // ---- DC step, DCB_SHIFT=4, unity gain: s=16000,15000,14063 -> y=1000,937,878
    snd_l_in = 16'sd1000; snd_r_in = -16'sd1000; gain = 8'd64; out_ready = 1'b1;
    reset_dut();
    get_sample(ok); check("dc1_ok", 32'(ok), 1);
    check("dc1_l", 32'(a_l), 1000);  check("dc1_r", 32'(a_r), -1000);
    get_sample(ok); check("dc2_ok", 32'(ok), 1);
    check("dc2_l", 32'(a_l), 937);   check("dc2_r", 32'(a_r), -938);
    get_sample(ok); check("dc3_ok", 32'(ok), 1);
    check("dc3_l", 32'(a_l), 878);   check("dc3_r", 32'(a_r), -879);
    n_bad = 0; prev_l = 878; prev_r = -879;
    for (int i = 0; i < 197; i++) begin
      get_sample(ok);
      if (!ok || (32'(a_l) > prev_l) || (32'(a_r) < prev_r)) n_bad++;
      prev_l = 32'(a_l); prev_r = 32'(a_r);
    end
    check("dc_monotonic_bad", n_bad, 0);
    check("dc_settled", 32'((a_l <= 1) && (a_l >= -1) && (a_r <= 1) && (a_r >= -1)), 1);
    check("dc_no_ovr", 32'(a_ovr), 0);

    // ---- reset mid-pipeline: second tick at cycle 6, reset during cycle 8
    out_ready = 1'b0;
    reset_dut();
    get_sample(ok); check("mid_ok", 32'(ok), 1);
    check("mid_first_l", 32'(a_l), 1000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_valid", 32'(a_valid), 0);
    check("mid_l",     32'(a_l), 0);
    check("mid_r",     32'(a_r), 0);
    check("mid_ovr",   32'(a_ovr), 0);
    reset = 1'b0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("mid_flush_c%0d", i), 32'(a_valid), 0);
    end
    @(negedge clk);
    check("mid_recover_v", 32'(a_valid), 1);
    check("mid_recover_l", 32'(a_l), 1000);

    // ---- handshake: hold sample 1, overwrite with sample 2, then accept
    out_ready = 1'b0;
    reset_dut();
    get_sample(ok); check("hs_ok", 32'(ok), 1);
    check("hs1_l", 32'(a_l), 1000); check("hs1_ovr", 32'(a_ovr), 0);
    @(negedge clk);
    check("hs_hold7_l", 32'(a_l), 1000); check("hs_hold7_v", 32'(a_valid), 1);
    @(negedge clk);
    check("hs_hold8_r", 32'(a_r), -1000); check("hs_hold8_ovr", 32'(a_ovr), 0);
    @(negedge clk);
    check("hs2_l", 32'(a_l), 937); check("hs2_r", 32'(a_r), -938);
    check("hs2_v", 32'(a_valid), 1); check("hs2_ovr", 32'(a_ovr), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_drop_v", 32'(a_valid), 0); check("hs_sticky_ovr", 32'(a_ovr), 1);

    // ---- load coincident with acceptance: no overrun
    out_ready = 1'b0;
    reset_dut();
    get_sample(ok); check("co_ok", 32'(ok), 1);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("co_v", 32'(a_valid), 1); check("co_l", 32'(a_l), 937);
    check("co_ovr", 32'(a_ovr), 0);
    @(negedge clk);
    check("co_drop_v", 32'(a_valid), 0);

    // ---- mute with input steps, gain 0.5; unmuted output continues the filter state
    snd_l_in = 16'sd800; snd_r_in = -16'sd800; gain = 8'd32; mute = 1'b1; out_ready = 1'b1;
    reset_dut();
    get_sample(ok); check("mute1_ok", 32'(ok), 1);
    check("mute1_l", 32'(a_l), 0); check("mute1_r", 32'(a_r), 0);
    snd_l_in = 16'sd1600; snd_r_in = -16'sd1600;
    get_sample(ok); check("mute2_ok", 32'(ok), 1);
    check("mute2_l", 32'(a_l), 0); check("mute2_r", 32'(a_r), 0);
    mute = 1'b0;
    get_sample(ok); check("unmute_ok", 32'(ok), 1);
    check("unmute_l", 32'(a_l), 726); check("unmute_r", 32'(a_r), -727);

    // ---- saturation on DCB_SHIFT=10 instance, gain 255
    snd_l_in = 16'sd20000; snd_r_in = -16'sd20000; gain = 8'd255; out_ready = 1'b1;
    reset_dut();
    get_sample(ok); check("sat1_ok", 32'(ok), 1);
    check("sat1_bv", 32'(b_valid), 1);
    check("sat1_l", 32'(b_l), 32767); check("sat1_r", 32'(b_r), -32768);
    snd_l_in = -16'sd20000; snd_r_in = 16'sd20000;
    get_sample(ok); check("sat2_ok", 32'(ok), 1);
    check("sat2_l", 32'(b_l), -32768); check("sat2_r", 32'(b_r), 32767);
    check("sat_b_ovr", 32'(b_ovr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
